// File: rtl/axil_wr_master_pkg.sv
// Shared AXI-Lite definitions: BRESP codes, write-master state encoding and
// the LED peripheral address map used by the slaves.
package axil_wr_master_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [31:0] LED_BASE = 32'h4000_0000;
    localparam logic [31:0] LED_CTRL = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        RESP,
        DONE
    } state_t;

endpackage

// File: rtl/axil_wr_master.sv
// Single-outstanding AXI-Lite write master: one command in, one AW/W/B
// transaction out, with a response or timeout report back to the source.
module axil_wr_master
    import axil_wr_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_data,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                cmd_ready_n, rsp_valid_n, rsp_timeout_n;
    logic [1:0]          rsp_resp_n;
    logic                awvalid_n, wvalid_n, bready_n;
    logic [ADDR_W-1:0]   awaddr_n;
    logic [DATA_W-1:0]   wdata_n;
    logic [STRB_W-1:0]   wstrb_n;
    logic                aw_fin, w_fin, expire;

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        cmd_ready_n   = cmd_ready;
        rsp_valid_n   = 1'b0;
        rsp_resp_n    = rsp_resp;
        rsp_timeout_n = rsp_timeout;
        awvalid_n     = m_awvalid;
        awaddr_n      = m_awaddr;
        wvalid_n      = m_wvalid;
        wdata_n       = m_wdata;
        wstrb_n       = m_wstrb;
        bready_n      = m_bready;
        expire        = 1'b0;
        // A channel is finished once its valid has dropped or it handshakes now.
        aw_fin        = !m_awvalid || m_awready;
        w_fin         = !m_wvalid || m_wready;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    awaddr_n    = cmd_addr;
                    wdata_n     = cmd_data;
                    wstrb_n     = cmd_strb;
                    awvalid_n   = 1'b1;
                    wvalid_n    = 1'b1;
                    cmd_ready_n = 1'b0;
                    cnt_n       = '0;
                    state_n     = ADDR_DATA;
                end
            end
            ADDR_DATA: begin
                cnt_n = cnt + 1'b1;
                if (m_awvalid && m_awready) awvalid_n = 1'b0;
                if (m_wvalid && m_wready)   wvalid_n  = 1'b0;
                if (cnt == TMAX) begin
                    expire = 1'b1;
                end else if (aw_fin && w_fin) begin
                    bready_n = 1'b1;
                    state_n  = RESP;
                end
            end
            RESP: begin
                cnt_n = cnt + 1'b1;
                if (m_bvalid && m_bready) begin
                    rsp_valid_n   = 1'b1;
                    rsp_resp_n    = m_bresp;
                    rsp_timeout_n = 1'b0;
                    bready_n      = 1'b0;
                    state_n       = DONE;
                end else if (cnt == TMAX) begin
                    expire = 1'b1;
                end
            end
            DONE: begin
                cmd_ready_n = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (expire) begin
            awvalid_n     = 1'b0;
            wvalid_n      = 1'b0;
            bready_n      = 1'b0;
            rsp_valid_n   = 1'b1;
            rsp_resp_n    = SLVERR;
            rsp_timeout_n = 1'b1;
            state_n       = DONE;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= IDLE;
            cnt         <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
            m_awvalid   <= 1'b0;
            m_awaddr    <= '0;
            m_wvalid    <= 1'b0;
            m_wlast     <= 1'b0;
            m_wdata     <= '0;
            m_wstrb     <= '0;
            m_bready    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cmd_ready   <= cmd_ready_n;
            rsp_valid   <= rsp_valid_n;
            rsp_resp    <= rsp_resp_n;
            rsp_timeout <= rsp_timeout_n;
            m_awvalid   <= awvalid_n;
            m_awaddr    <= awaddr_n;
            m_wvalid    <= wvalid_n;
            m_wlast     <= wvalid_n;
            m_wdata     <= wdata_n;
            m_wstrb     <= wstrb_n;
            m_bready    <= bready_n;
        end
    end

endmodule

// File: tb/tb_axil_wr_master.sv
// Directed bench for axil_wr_master against a configurable LED slave model.
module tb_axil_wr_master;
    import axil_wr_master_pkg::*;

    localparam logic [31:0] LED_ADDR = LED_BASE + LED_CTRL;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic        m_awvalid, m_awready;
    logic [31:0] m_awaddr;
    logic        m_wvalid, m_wready, m_wlast;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_bvalid, m_bready;
    logic [1:0]  m_bresp;

    always #5 aclk = ~aclk;

    axil_wr_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Slave model knobs
    int         aw_dly = 0, w_dly = 0;
    logic       never_aw = 1'b0, never_b = 1'b0, slv_clr = 1'b0;
    logic [1:0] b_code = 2'b00;

    // Slave model state
    int          aw_wait, w_wait;
    logic        aw_got, w_got, b_linger;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, wr_count = 0;
    logic [7:0]  led = 8'h00;

    always @(posedge aclk) begin
        if (areset || slv_clr) begin
            m_awready <= 1'b0; m_wready <= 1'b0;
            m_bvalid  <= 1'b0; m_bresp  <= 2'b00;
            aw_wait <= 0; w_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_linger <= 1'b0;
        end else begin
            if (m_awvalid && m_awready) begin
                m_awready <= 1'b0; aw_wait <= 0; aw_got <= 1'b1;
                aw_addr_q <= m_awaddr; aw_hs <= aw_hs + 1;
            end else if (m_awvalid && !never_aw && aw_wait >= aw_dly) begin
                m_awready <= 1'b1;
            end else begin
                m_awready <= 1'b0;
                if (m_awvalid) aw_wait <= aw_wait + 1;
            end

            if (m_wvalid && m_wready) begin
                m_wready <= 1'b0; w_wait <= 0; w_got <= 1'b1;
                w_data_q <= m_wdata; w_strb_q <= m_wstrb; w_hs <= w_hs + 1;
            end else if (m_wvalid && m_wlast && w_wait >= w_dly) begin
                m_wready <= 1'b1;
            end else begin
                m_wready <= 1'b0;
                if (m_wvalid) w_wait <= w_wait + 1;
            end

            // bvalid lingers one cycle after its handshake
            if (m_bvalid && m_bready) begin
                b_hs <= b_hs + 1; b_linger <= 1'b1;
            end else if (b_linger) begin
                m_bvalid <= 1'b0; b_linger <= 1'b0;
            end else if (!m_bvalid && aw_got && w_got && !never_b) begin
                m_bvalid <= 1'b1; m_bresp <= b_code;
                aw_got <= 1'b0; w_got <= 1'b0; wr_count <= wr_count + 1;
                if (aw_addr_q == LED_ADDR && w_strb_q[0]) led <= w_data_q[7:0];
            end
        end
    end

    int cyc = 0, acc_count = 0, acc_last = -100, min_gap = 1000, rsp_count = 0;

    always @(posedge aclk) begin
        cyc++;
        if (!areset && cmd_valid && cmd_ready) begin
            if (cyc - acc_last < min_gap) min_gap = cyc - acc_last;
            acc_last = cyc;
            acc_count++;
        end
        if (rsp_valid) rsp_count++;
    end

    int         rsp_at;
    logic [3:0] vals_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit hold);
        int start;
        start = acc_count;
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_strb = s;
        for (int i = 0; i < 200 && acc_count == start; i++) @(negedge aclk);
        check("cmd_accept", 32'(acc_count - start), 32'd1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [1:0] exp_resp, input logic exp_to);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge aclk);
            seen = rsp_valid;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_resp"}, 32'(rsp_resp), 32'(exp_resp));
        check({tag, "_timeout"}, 32'(rsp_timeout), 32'(exp_to));
        rsp_at  = cyc;
        vals_at = {m_awvalid, m_wvalid, m_wlast, m_bready};
        @(negedge aclk);
        check({tag, "_one_pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp"}, 32'({rsp_valid, rsp_resp, rsp_timeout}), 32'd0);
        check({tag, "_valids"}, 32'({m_awvalid, m_wvalid, m_wlast, m_bready}), 32'd0);
        check({tag, "_awaddr"}, m_awaddr, 32'd0);
        check({tag, "_wdata"}, m_wdata, 32'd0);
        check({tag, "_wstrb"}, 32'(m_wstrb), 32'd0);
    endtask

    initial begin
        int t0, base_aw, base_w, base_wr, base_rsp;
        bit seen;

        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        areset = 1'b0;
        @(negedge aclk);

        // Basic LED write
        send(LED_ADDR, 32'h0000_00A5, 4'hF, 1'b0);
        check("basic_valids", 32'({m_awvalid, m_wvalid, m_wlast, cmd_ready}), 32'hE);
        check("basic_awaddr", m_awaddr, LED_ADDR);
        check("basic_wdata", m_wdata, 32'h0000_00A5);
        check("basic_wstrb", 32'(m_wstrb), 32'hF);
        wait_rsp("basic", OKAY, 1'b0);
        check("basic_led", 32'(led), 32'hA5);

        // Handshake orderings: W first, AW first, both together
        for (int k = 0; k < 3; k++) begin
            aw_dly = (k == 0) ? 3 : 0;
            w_dly  = (k == 1) ? 3 : 0;
            base_aw = aw_hs; base_w = w_hs;
            send(LED_ADDR, 32'h1234_5678, 4'hF, 1'b0);
            wait_rsp($sformatf("order%0d", k), OKAY, 1'b0);
            check($sformatf("order%0d_aw_hs", k), 32'(aw_hs - base_aw), 32'd1);
            check($sformatf("order%0d_w_hs", k), 32'(w_hs - base_w), 32'd1);
            check($sformatf("order%0d_wdata", k), w_data_q, 32'h1234_5678);
            check($sformatf("order%0d_led", k), 32'(led), 32'h78);
        end
        aw_dly = 0; w_dly = 0;

        // Error response passes through
        b_code = SLVERR;
        send(LED_ADDR, 32'h0000_0011, 4'hF, 1'b0);
        wait_rsp("slverr", SLVERR, 1'b0);
        b_code = OKAY;

        // Timeout: slave never accepts the address
        never_aw = 1'b1;
        base_aw = aw_hs;
        send(LED_ADDR, 32'h0000_0055, 4'hF, 1'b0);
        t0 = cyc;
        wait_rsp("tmo", SLVERR, 1'b1);
        check("tmo_latency", 32'(rsp_at - t0), 32'd16);
        check("tmo_valids_drop", 32'(vals_at), 32'd0);
        check("tmo_no_aw", 32'(aw_hs - base_aw), 32'd0);
        never_aw = 1'b0;
        slv_clr = 1'b1;
        @(negedge aclk);
        slv_clr = 1'b0;
        send(LED_ADDR, 32'h0000_003C, 4'hF, 1'b0);
        wait_rsp("after_tmo", OKAY, 1'b0);
        check("after_tmo_led", 32'(led), 32'h3C);

        // Back-to-back with cmd_valid held high
        min_gap = 1000; base_wr = wr_count; base_rsp = rsp_count;
        send(LED_ADDR, 32'h01, 4'hF, 1'b1);
        send(LED_ADDR, 32'h02, 4'hF, 1'b1);
        send(LED_ADDR, 32'h04, 4'hF, 1'b1);
        send(LED_ADDR, 32'h08, 4'hF, 1'b0);
        for (int i = 0; i < 100 && rsp_count - base_rsp < 4; i++) @(negedge aclk);
        repeat (10) @(negedge aclk);
        check("b2b_rsp_count", 32'(rsp_count - base_rsp), 32'd4);
        check("b2b_writes", 32'(wr_count - base_wr), 32'd4);
        check("b2b_led", 32'(led), 32'h08);
        check("b2b_gap_ge5", 32'(min_gap >= 5), 32'd1);

        // Reset while waiting for B
        never_b = 1'b1;
        send(LED_ADDR, 32'hDEAD_BEEF, 4'hF, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge aclk);
            seen = m_bready;
        end
        check("mid_in_resp", 32'(seen), 32'd1);
        base_rsp = rsp_count;
        areset = 1'b1;
        @(negedge aclk);
        check_reset_outputs("mid_reset");
        areset = 1'b0;
        never_b = 1'b0;
        repeat (5) @(negedge aclk);
        check("mid_no_rsp", 32'(rsp_count - base_rsp), 32'd0);
        send(LED_ADDR, 32'h0000_0081, 4'hF, 1'b0);
        wait_rsp("post_rst", OKAY, 1'b0);
        check("post_rst_led", 32'(led), 32'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1);
    end

endmodule
